// File: rtl/alarm_sequencer.sv
// alarm_sequencer: turns per-sensor alarm levels into siren/strobe drive.
// Handles the door entry delay, the intrusion siren with auto-silence, the
// fire alarm and user acknowledge. It also keeps a sticky cause and a
// saturating activation count for the status display. All outputs are
// registered, so each response appears one edge after its input.
module alarm_sequencer #(
    parameter int ENTRY_DLY     = 8,
    parameter int SIREN_HALF    = 4,
    parameter int SIREN_TIMEOUT = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dooralarm,
    input  logic       windowalarm,
    input  logic       firealarm,
    input  logic       ack,
    output logic       siren,
    output logic       strobe,
    output logic [2:0] alarm_cause,
    output logic [2:0] seq_state,
    output logic [7:0] event_count
);

    typedef enum logic [2:0] {
        QUIET    = 3'd0,
        ENTRY    = 3'd1,
        INTRUDE  = 3'd2,
        FIRE     = 3'd3,
        SILENCED = 3'd4
    } state_t;

    // Terminal values of the three counters, expressed at their own widths
    localparam logic [7:0]  ENTRY_LOAD = 8'(ENTRY_DLY - 1);
    localparam logic [7:0]  PHASE_LAST = 8'(SIREN_HALF - 1);
    localparam logic [15:0] RUN_LAST   = 16'(SIREN_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  entry_timer_q;
    logic [7:0]  entry_timer_d;
    logic [15:0] run_timer_q;
    logic [15:0] run_timer_d;
    logic [7:0]  phase_q;
    logic [7:0]  phase_d;
    logic        siren_d;
    logic        strobe_d;
    logic [2:0]  cause_d;
    logic [7:0]  count_d;
    logic        door_prev_q;
    logic        window_prev_q;
    logic        door_rise;
    logic        window_rise;
    logic        intrude_start;
    logic        count_event;

    assign door_rise   = dooralarm & ~door_prev_q;
    assign window_rise = windowalarm & ~window_prev_q;
    assign seq_state   = state_q;

    // State and datapath registers, all cleared by the synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= QUIET;
            entry_timer_q <= 8'd0;
            run_timer_q   <= 16'd0;
            phase_q       <= 8'd0;
            siren         <= 1'b0;
            strobe        <= 1'b0;
            alarm_cause   <= 3'd0;
            event_count   <= 8'd0;
            door_prev_q   <= 1'b0;
            window_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_timer_q <= entry_timer_d;
            run_timer_q   <= run_timer_d;
            phase_q       <= phase_d;
            siren         <= siren_d;
            strobe        <= strobe_d;
            alarm_cause   <= cause_d;
            event_count   <= count_d;
            door_prev_q   <= dooralarm;
            window_prev_q <= windowalarm;
        end
    end

    // Next-state selection with fire > window > door > ack priority;
    // in ENTRY an acknowledge wins over expiry of the entry timer
    always_comb begin
        state_d       = state_q;
        entry_timer_d = entry_timer_q;
        case (state_q)
            QUIET: begin
                if (firealarm) begin
                    state_d = FIRE;
                end else if (windowalarm) begin
                    state_d = INTRUDE;
                end else if (dooralarm) begin
                    state_d       = ENTRY;
                    entry_timer_d = ENTRY_LOAD;
                end
            end
            ENTRY: begin
                if (firealarm) begin
                    state_d = FIRE;
                end else if (windowalarm) begin
                    state_d = INTRUDE;
                end else if (ack) begin
                    state_d = QUIET;
                end else if (entry_timer_q == 8'd0) begin
                    state_d = INTRUDE;
                end else begin
                    entry_timer_d = entry_timer_q - 8'd1;
                end
            end
            INTRUDE: begin
                if (firealarm) begin
                    state_d = FIRE;
                end else if (ack) begin
                    state_d = QUIET;
                end else if (run_timer_q == RUN_LAST) begin
                    state_d = SILENCED;
                end
            end
            FIRE: begin
                if (!firealarm && ack) begin
                    state_d = QUIET;
                end
            end
            SILENCED: begin
                if (firealarm) begin
                    state_d = FIRE;
                end else if (window_rise || door_rise) begin
                    state_d = INTRUDE;
                end else if (ack) begin
                    state_d = QUIET;
                end
            end
            default: state_d = QUIET;
        endcase
    end

    // Output drive, siren cadence and run timer, all derived from the state being entered
    always_comb begin
        intrude_start = (state_d == INTRUDE) && (state_q != INTRUDE);
        run_timer_d   = run_timer_q;
        phase_d       = phase_q;
        siren_d       = 1'b0;
        strobe_d      = 1'b0;
        case (state_d)
            INTRUDE: begin
                strobe_d = 1'b1;
                if (intrude_start) begin
                    run_timer_d = 16'd0;
                    phase_d     = 8'd0;
                    siren_d     = 1'b1;
                end else begin
                    siren_d = siren;
                    if (run_timer_q != RUN_LAST) begin
                        run_timer_d = run_timer_q + 16'd1;
                    end
                    if (phase_q == PHASE_LAST) begin
                        phase_d = 8'd0;
                        siren_d = ~siren;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            FIRE: begin
                siren_d  = 1'b1;
                strobe_d = 1'b1;
            end
            SILENCED: begin
                strobe_d = 1'b1;
            end
            default: begin
                siren_d  = 1'b0;
                strobe_d = 1'b0;
            end
        endcase
    end

    // Sticky cause and saturating activation count; re-arming from SILENCED
    // continues the same intrusion and so is not a new activation
    always_comb begin
        cause_d     = 3'd0;
        count_d     = event_count;
        count_event = 1'b0;
        if (state_d != QUIET) begin
            cause_d = alarm_cause | {firealarm, windowalarm, dooralarm};
        end
        if ((state_d == INTRUDE || state_d == FIRE) && (state_d != state_q) &&
            !(state_q == SILENCED && state_d == INTRUDE)) begin
            count_event = 1'b1;
        end
        if (count_event && event_count != 8'hFF) begin
            count_d = event_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed testbench for alarm_sequencer with default parameters
// (ENTRY_DLY=8, SIREN_HALF=4, SIREN_TIMEOUT=32).
module tb_alarm_sequencer;

    logic       clock;
    logic       reset;
    logic       dooralarm;
    logic       windowalarm;
    logic       firealarm;
    logic       ack;
    logic       siren;
    logic       strobe;
    logic [2:0] alarm_cause;
    logic [2:0] seq_state;
    logic [7:0] event_count;

    int checks = 0;
    int passes = 0;

    alarm_sequencer #(
        .ENTRY_DLY(8),
        .SIREN_HALF(4),
        .SIREN_TIMEOUT(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dooralarm(dooralarm),
        .windowalarm(windowalarm),
        .firealarm(firealarm),
        .ack(ack),
        .siren(siren),
        .strobe(strobe),
        .alarm_cause(alarm_cause),
        .seq_state(seq_state),
        .event_count(event_count)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        dooralarm   = 1'b0;
        windowalarm = 1'b0;
        firealarm   = 1'b0;
        ack         = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset     = 1'b0;
        firealarm = 1'b1;
        tick();
        tick();
        checks++;
        if ({seq_state, siren, strobe, alarm_cause, event_count} !== 16'd0)
            $display("[TB] FAIL reset_outputs: state=%0d siren=%b strobe=%b cause=%b count=%0d, expected all 0",
                     seq_state, siren, strobe, alarm_cause, event_count);
        else passes++;
        firealarm = 1'b0;
        reset     = 1'b1;
        tick();
        checks++;
        if (seq_state !== 3'd0)
            $display("[TB] FAIL reset_release: state=%0d expected 0", seq_state);
        else passes++;
    endtask

    task automatic test_door_trip();
        logic exp_siren;
        do_reset();
        dooralarm = 1'b1;
        tick();
        dooralarm = 1'b0;
        checks++;
        if (seq_state !== 3'd1 || siren !== 1'b0)
            $display("[TB] FAIL door_entry_edge0: state=%0d siren=%b, expected 1/0", seq_state, siren);
        else passes++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (seq_state !== 3'd1 || siren !== 1'b0 || strobe !== 1'b0)
                $display("[TB] FAIL door_entry_edge%0d: state=%0d siren=%b strobe=%b, expected 1/0/0",
                         k, seq_state, siren, strobe);
            else passes++;
        end
        tick();
        checks++;
        if (seq_state !== 3'd2 || siren !== 1'b1 || strobe !== 1'b1 ||
            alarm_cause !== 3'b001 || event_count !== 8'd1)
            $display("[TB] FAIL door_intrude_edge8: state=%0d siren=%b strobe=%b cause=%b count=%0d, expected 2/1/1/001/1",
                     seq_state, siren, strobe, alarm_cause, event_count);
        else passes++;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_siren = ((k / 4) % 2) == 0;
            checks++;
            if (siren !== exp_siren || seq_state !== 3'd2)
                $display("[TB] FAIL door_siren_cadence_edge%0d: siren=%b state=%0d, expected %b/2",
                         8 + k, siren, seq_state, exp_siren);
            else passes++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (seq_state !== 3'd0 || siren !== 1'b0 || strobe !== 1'b0 ||
            alarm_cause !== 3'd0 || event_count !== 8'd1)
            $display("[TB] FAIL door_ack_quiet: state=%0d siren=%b strobe=%b cause=%b count=%0d, expected 0/0/0/000/1",
                     seq_state, siren, strobe, alarm_cause, event_count);
        else passes++;
    endtask

    task automatic test_door_ack();
        do_reset();
        dooralarm = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (seq_state !== 3'd1 || siren !== 1'b0)
                $display("[TB] FAIL door_ack_entry_edge%0d: state=%0d siren=%b, expected 1/0", k, seq_state, siren);
            else passes++;
        end
        dooralarm = 1'b0;
        ack       = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (seq_state !== 3'd0 || alarm_cause !== 3'd0 || event_count !== 8'd0 || siren !== 1'b0)
            $display("[TB] FAIL door_ack_edge5: state=%0d cause=%b count=%0d siren=%b, expected 0/000/0/0",
                     seq_state, alarm_cause, event_count, siren);
        else passes++;
    endtask

    task automatic test_window_timeout();
        do_reset();
        windowalarm = 1'b1;
        tick();
        windowalarm = 1'b0;
        checks++;
        if (seq_state !== 3'd2 || siren !== 1'b1 || strobe !== 1'b1 ||
            alarm_cause !== 3'b010 || event_count !== 8'd1)
            $display("[TB] FAIL window_intrude: state=%0d siren=%b strobe=%b cause=%b count=%0d, expected 2/1/1/010/1",
                     seq_state, siren, strobe, alarm_cause, event_count);
        else passes++;
        for (int k = 1; k <= 31; k++) tick();
        checks++;
        if (seq_state !== 3'd2)
            $display("[TB] FAIL window_last_intrude_edge31: state=%0d expected 2", seq_state);
        else passes++;
        tick();
        checks++;
        if (seq_state !== 3'd4 || siren !== 1'b0 || strobe !== 1'b1)
            $display("[TB] FAIL window_silenced_edge32: state=%0d siren=%b strobe=%b, expected 4/0/1",
                     seq_state, siren, strobe);
        else passes++;
        tick();
        checks++;
        if (seq_state !== 3'd4)
            $display("[TB] FAIL window_silenced_hold: state=%0d expected 4", seq_state);
        else passes++;
        windowalarm = 1'b1;
        tick();
        checks++;
        if (seq_state !== 3'd2 || siren !== 1'b1 || event_count !== 8'd1)
            $display("[TB] FAIL window_retrigger: state=%0d siren=%b count=%0d, expected 2/1/1",
                     seq_state, siren, event_count);
        else passes++;
        for (int k = 1; k <= 32; k++) tick();
        checks++;
        if (seq_state !== 3'd4)
            $display("[TB] FAIL window_retrigger_timeout: state=%0d expected 4", seq_state);
        else passes++;
        tick();
        checks++;
        if (seq_state !== 3'd4 || event_count !== 8'd1)
            $display("[TB] FAIL window_level_no_rearm: state=%0d count=%0d, expected 4/1", seq_state, event_count);
        else passes++;
        windowalarm = 1'b0;
    endtask

    task automatic test_fire_during_intrude();
        do_reset();
        windowalarm = 1'b1;
        tick();
        windowalarm = 1'b0;
        tick();
        tick();
        tick();
        firealarm = 1'b1;
        tick();
        checks++;
        if (seq_state !== 3'd3 || siren !== 1'b1 || strobe !== 1'b1 ||
            alarm_cause !== 3'b110 || event_count !== 8'd2)
            $display("[TB] FAIL fire_from_intrude: state=%0d siren=%b strobe=%b cause=%b count=%0d, expected 3/1/1/110/2",
                     seq_state, siren, strobe, alarm_cause, event_count);
        else passes++;
        ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (seq_state !== 3'd3 || siren !== 1'b1)
                $display("[TB] FAIL fire_ack_ignored_%0d: state=%0d siren=%b, expected 3/1", k, seq_state, siren);
            else passes++;
        end
        firealarm = 1'b0;
        tick();
        ack = 1'b0;
        checks++;
        if (seq_state !== 3'd0 || siren !== 1'b0 || strobe !== 1'b0 ||
            alarm_cause !== 3'd0 || event_count !== 8'd2)
            $display("[TB] FAIL fire_ack_quiet: state=%0d siren=%b strobe=%b cause=%b count=%0d, expected 0/0/0/000/2",
                     seq_state, siren, strobe, alarm_cause, event_count);
        else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        firealarm   = 1'b1;
        windowalarm = 1'b1;
        dooralarm   = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (seq_state !== 3'd3 || alarm_cause !== 3'b111 || event_count !== 8'd1)
            $display("[TB] FAIL simultaneous_fire: state=%0d cause=%b count=%0d, expected 3/111/1",
                     seq_state, alarm_cause, event_count);
        else passes++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (seq_state !== 3'd0 || alarm_cause !== 3'd0)
            $display("[TB] FAIL simultaneous_ack: state=%0d cause=%b, expected 0/000", seq_state, alarm_cause);
        else passes++;
    endtask

    task automatic test_ack_expiry();
        do_reset();
        dooralarm = 1'b1;
        tick();
        dooralarm = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (seq_state !== 3'd0 || siren !== 1'b0 || event_count !== 8'd0)
            $display("[TB] FAIL ack_beats_expiry: state=%0d siren=%b count=%0d, expected 0/0/0",
                     seq_state, siren, event_count);
        else passes++;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            firealarm = 1'b1;
            tick();
            firealarm = 1'b0;
            ack       = 1'b1;
            tick();
            ack = 1'b0;
            if (k == 255) begin
                checks++;
                if (event_count !== 8'd255)
                    $display("[TB] FAIL count_at_255: count=%0d expected 255", event_count);
                else passes++;
            end
        end
        checks++;
        if (event_count !== 8'd255 || seq_state !== 3'd0)
            $display("[TB] FAIL count_saturated: count=%0d state=%0d, expected 255/0", event_count, seq_state);
        else passes++;
        windowalarm = 1'b1;
        tick();
        windowalarm = 1'b0;
        tick();
        tick();
        checks++;
        if (seq_state !== 3'd2 || event_count !== 8'd255)
            $display("[TB] FAIL intrude_saturated: state=%0d count=%0d, expected 2/255", seq_state, event_count);
        else passes++;
        reset = 1'b0;
        tick();
        checks++;
        if ({seq_state, siren, strobe, alarm_cause, event_count} !== 16'd0)
            $display("[TB] FAIL reset_mid_intrude: state=%0d siren=%b strobe=%b cause=%b count=%0d, expected all 0",
                     seq_state, siren, strobe, alarm_cause, event_count);
        else passes++;
        reset = 1'b1;
        tick();
        checks++;
        if (seq_state !== 3'd0 || siren !== 1'b0)
            $display("[TB] FAIL after_reset_quiet: state=%0d siren=%b, expected 0/0", seq_state, siren);
        else passes++;
    endtask

    // Run each scenario in sequence and report the tally
    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_door_trip();
        test_door_ack();
        test_window_timeout();
        test_fire_during_intrude();
        test_simultaneous();
        test_ack_expiry();
        test_saturation_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
